// File: rtl/max_unpool_pkg.sv
// Shared definitions for the max-pool / max-unpool pair.
//   DATA_W  : pooled value width
//   ADDR_W  : linear output address width (SIZE*SIZE <= 64)
//   HIS_W   : argmax history code width
//   HIS_*   : window position codes, shared with the pooling stage
//   state_e : unpool sequencer states
package max_unpool_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned HIS_W  = 3;

  localparam logic [HIS_W-1:0] HIS_TL = 3'd0;
  localparam logic [HIS_W-1:0] HIS_TR = 3'd1;
  localparam logic [HIS_W-1:0] HIS_BL = 3'd2;
  localparam logic [HIS_W-1:0] HIS_BR = 3'd3;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/max_unpool_if.sv
// Bus between the pooled-sample producer and the unpool stage.
//   load/in/history : one pooled sample and its argmax code (producer -> unpool)
//   result/addr     : reconstructed element and its linear address
//   out_valid       : result/addr valid
//   busy            : unpool is not accepting loads
//   done_up         : one-cycle end-of-frame pulse
interface max_unpool_if;
  import max_unpool_pkg::*;

  logic              load;
  logic [DATA_W-1:0] in;
  logic [HIS_W-1:0]  history;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] addr;
  logic              out_valid;
  logic              busy;
  logic              done_up;

  modport master (
    output load, in, history,
    input  result, addr, out_valid, busy, done_up
  );

  modport slave (
    input  load, in, history,
    output result, addr, out_valid, busy, done_up
  );

endinterface

// File: rtl/max_unpool_sel.sv
// Combinational window selector: passes the pooled value through only at the
// window position named by its history code, zero elsewhere.
//   value    : pooled value of the window
//   history  : argmax code of the window (codes 4..7 match nothing)
//   row_odd  : output row is the bottom row of the window
//   col_odd  : output column is the right column of the window
//   result_c : reconstructed element
module max_unpool_sel
  import max_unpool_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [HIS_W-1:0]  history,
  input  logic              row_odd,
  input  logic              col_odd,
  output logic [DATA_W-1:0] result_c
);

  logic [HIS_W-1:0] pos_c;

  // Code of the window position being produced; compared on all history bits.
  always_comb begin
    pos_c = HIS_TL;
    case ({row_odd, col_odd})
      2'b00:   pos_c = HIS_TL;
      2'b01:   pos_c = HIS_TR;
      2'b10:   pos_c = HIS_BL;
      2'b11:   pos_c = HIS_BR;
      default: pos_c = HIS_TL;
    endcase
    result_c = (history == pos_c) ? value : '0;
  end

endmodule

// File: rtl/max_unpool.sv
// 2x2 max-unpool: buffers an N x N pooled map with argmax codes, then streams
// the rebuilt 2N x 2N map in raster order, one element per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of max_unpool_if (load/in/history in;
//                result/addr/out_valid/busy/done_up out, all registered)
module max_unpool
  import max_unpool_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  max_unpool_if.slave  bus
);

  localparam int unsigned SIZE   = 2 * N;
  localparam int unsigned NN     = N * N;
  localparam int unsigned LCNT_W = (NN > 1) ? $clog2(NN) : 1;
  // Row counter reaches SIZE for one cycle to mark the end of the scan.
  localparam int unsigned ROW_W  = $clog2(SIZE + 1);
  localparam int unsigned COL_W  = $clog2(SIZE);

  state_e            state_q, state_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;

  logic [DATA_W-1:0] result_d;
  logic [ADDR_W-1:0] addr_d;
  logic              out_valid_d;
  logic              busy_d;
  logic              done_up_d;
  logic              wr_en_c;

  logic [DATA_W-1:0] val_mem [NN];
  logic [HIS_W-1:0]  his_mem [NN];

  logic [LCNT_W-1:0] rd_idx_c;
  logic [DATA_W-1:0] sel_result_c;

  // Pooled sample feeding the current output element.
  assign rd_idx_c = LCNT_W'((32'(row_q) >> 1) * N + (32'(col_q) >> 1));

  max_unpool_sel u_sel (
    .value    (val_mem[rd_idx_c]),
    .history  (his_mem[rd_idx_c]),
    .row_odd  (row_q[0]),
    .col_odd  (col_q[0]),
    .result_c (sel_result_c)
  );

  // Sample buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      val_mem[lcnt_q] <= bus.in;
      his_mem[lcnt_q] <= bus.history;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    row_d       = row_q;
    col_d       = col_q;
    result_d    = '0;
    addr_d      = '0;
    out_valid_d = 1'b0;
    done_up_d   = 1'b0;
    wr_en_c     = 1'b0;

    case (state_q)
      LOAD: begin
        if (bus.load) begin
          wr_en_c = 1'b1;
          if (lcnt_q == LCNT_W'(NN - 1)) begin
            lcnt_d  = '0;
            state_d = EMIT;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
      end

      EMIT: begin
        if (row_q == ROW_W'(SIZE)) begin
          // Scan finished on the previous edge; raise the end-of-frame pulse.
          row_d     = '0;
          col_d     = '0;
          done_up_d = 1'b1;
          state_d   = DONE;
        end else begin
          out_valid_d = 1'b1;
          result_d    = sel_result_c;
          addr_d      = ADDR_W'(32'(row_q) * SIZE + 32'(col_q));
          if (col_q == COL_W'(SIZE - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      DONE: begin
        state_d = LOAD;
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    busy_d = (state_d != LOAD);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      lcnt_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      bus.result    <= '0;
      bus.addr      <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done_up   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lcnt_q        <= lcnt_d;
      row_q         <= row_d;
      col_q         <= col_d;
      bus.result    <= result_d;
      bus.addr      <= addr_d;
      bus.out_valid <= out_valid_d;
      bus.busy      <= busy_d;
      bus.done_up   <= done_up_d;
    end
  end

endmodule
